// File: rtl/control32_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit and its decode table.
package control32_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IF  = 3'd0;
    localparam logic [ST_W-1:0] ST_ID  = 3'd1;
    localparam logic [ST_W-1:0] ST_EX  = 3'd2;
    localparam logic [ST_W-1:0] ST_MEM = 3'd3;
    localparam logic [ST_W-1:0] ST_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic       jr;
        logic       jmp;
        logic       jal;
        logic       branch;
        logic       nbranch;
        logic       sftmd;
        logic       i_format;
        logic       lw;
        logic       sw;
        logic [1:0] alu_op;
        logic       supported;
    } dec_t;

endpackage

// File: rtl/control32_dec.sv
// Single-cycle MIPS32 decode table: opcode/funct to control levels, purely combinational.
module control32_dec
    import control32_pkg::*;
#(
    parameter int unsigned OPW = 6,
    parameter int unsigned FNW = 6
) (
    input  logic [OPW-1:0] i_op,
    input  logic [FNW-1:0] i_fn,
    output dec_t           o_dec_c
);

    logic w_r;
    logic w_i;
    logic w_lw;
    logic w_sw;
    logic w_jmp;
    logic w_jal;
    logic w_beq;
    logic w_bne;

    assign w_r   = (i_op == OPW'(OP_RTYPE));
    assign w_i   = (i_op[OPW-1 -: 3] == 3'b001);
    assign w_lw  = (i_op == OPW'(OP_LW));
    assign w_sw  = (i_op == OPW'(OP_SW));
    assign w_jmp = (i_op == OPW'(OP_J));
    assign w_jal = (i_op == OPW'(OP_JAL));
    assign w_beq = (i_op == OPW'(OP_BEQ));
    assign w_bne = (i_op == OPW'(OP_BNE));

    always_comb begin
        o_dec_c            = '0;
        o_dec_c.reg_dst    = w_r;
        o_dec_c.mem_to_reg = w_lw;
        o_dec_c.alu_src    = w_i | w_lw | w_sw;
        o_dec_c.jr         = w_r & (i_fn == FNW'(FN_JR));
        o_dec_c.jmp        = w_jmp;
        o_dec_c.jal        = w_jal;
        o_dec_c.branch     = w_beq;
        o_dec_c.nbranch    = w_bne;
        o_dec_c.sftmd      = w_r & (i_fn[FNW-1 -: 3] == 3'b000);
        o_dec_c.i_format   = w_i;
        o_dec_c.lw         = w_lw;
        o_dec_c.sw         = w_sw;
        o_dec_c.supported  = w_r | w_i | w_lw | w_sw | w_jmp | w_jal | w_beq | w_bne;
        if (w_beq | w_bne) begin
            o_dec_c.alu_op = ALUOP_BR;
        end else if (w_r | w_i) begin
            o_dec_c.alu_op = ALUOP_RI;
        end else begin
            o_dec_c.alu_op = ALUOP_MEM;
        end
    end

endmodule

// File: rtl/control32_mc.sv
// Multi-cycle MIPS32 control: IF/ID/EX/MEM/WB sequencer with memory handshake,
// stall hold, instruction latch and retired-instruction counter.
module control32_mc
    import control32_pkg::*;
#(
    parameter int unsigned OPW           = 6,
    parameter int unsigned FNW           = 6,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OPW-1:0]   Opcode,
    input  logic [FNW-1:0]   Function_opcode,
    input  logic             mem_ready,
    input  logic             stall,
    output logic [2:0]       state,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDST,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             Jr,
    output logic             Jmp,
    output logic             Jal,
    output logic             Branch,
    output logic             nBranch,
    output logic             Sftmd,
    output logic             I_format,
    output logic [1:0]       ALUOp,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_next;
    logic [OPW-1:0]   r_op;
    logic [FNW-1:0]   r_fn;
    logic             r_done;
    logic [CNT_W-1:0] r_count;

    dec_t w_dec;
    logic w_ready;
    logic w_active;
    logic w_jump;
    logic w_retire;
    logic w_irwrite;
    logic w_pcwrite;
    logic w_memread;
    logic w_memwrite;
    logic w_regwrite;

    control32_dec #(
        .OPW (OPW),
        .FNW (FNW)
    ) u_dec (
        .i_op    (r_op),
        .i_fn    (r_fn),
        .o_dec_c (w_dec)
    );

    // Fixed one-cycle memory when the handshake is not used.
    assign w_ready  = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_active = (r_state != ST_IF);
    assign w_jump   = w_dec.jr | w_dec.jmp | w_dec.jal | w_dec.branch | w_dec.nbranch;

    // Next state and per-state strobes; stall freezes the state and kills write strobes.
    always_comb begin
        w_next     = r_state;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        case (r_state)
            ST_IF: begin
                w_memread = 1'b1;
                if (w_ready && !stall) begin
                    w_irwrite = 1'b1;
                    w_next    = ST_ID;
                end
            end
            ST_ID: begin
                if (!stall) begin
                    w_next = w_dec.supported ? ST_EX : ST_IF;
                end
            end
            ST_EX: begin
                w_pcwrite = w_jump & ~stall;
                if (!stall) begin
                    if (w_dec.jal) begin
                        w_next = ST_WB;
                    end else if (w_jump) begin
                        w_next = ST_IF;
                    end else if (w_dec.lw || w_dec.sw) begin
                        w_next = ST_MEM;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_MEM: begin
                w_memread  = w_dec.lw;
                w_memwrite = ~w_dec.lw & ~stall;
                if (w_ready && !stall) begin
                    w_next = w_dec.lw ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                w_regwrite = ~stall;
                if (!stall) begin
                    w_next = ST_IF;
                end
            end
            default: begin
                w_next = ST_IF;
            end
        endcase
    end

    // Retirement is any return to IF from a legal in-flight state.
    assign w_retire = (r_state == ST_ID || r_state == ST_EX || r_state == ST_MEM ||
                       r_state == ST_WB) && (w_next == ST_IF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IF;
            r_op    <= '0;
            r_fn    <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_retire;
            if (w_irwrite) begin
                r_op <= Opcode;
                r_fn <= Function_opcode;
            end
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign state       = r_state;
    assign IRWrite     = w_irwrite;
    assign PCWrite     = w_pcwrite;
    assign MemRead     = w_memread;
    assign MemWrite    = w_memwrite;
    assign RegWrite    = w_regwrite;
    assign RegDST      = w_active & w_dec.reg_dst;
    assign MemtoReg    = w_active & w_dec.mem_to_reg;
    assign ALUSrc      = w_active & w_dec.alu_src;
    assign Jr          = w_active & w_dec.jr;
    assign Jmp         = w_active & w_dec.jmp;
    assign Jal         = w_active & w_dec.jal;
    assign Branch      = w_active & w_dec.branch;
    assign nBranch     = w_active & w_dec.nbranch;
    assign Sftmd       = w_active & w_dec.sftmd;
    assign I_format    = w_active & w_dec.i_format;
    assign ALUOp       = w_active ? w_dec.alu_op : 2'b00;
    assign instr_done  = r_done;
    assign instr_count = r_count;

endmodule
